// File: rtl/flow_ctrl_fsm.sv
// flow_ctrl_fsm: supervises NUM_CH FIFO occupancies and drives pause/continue/overflow flags.
// Ports: clk, reset (sync, active-high), init (request (re)initialisation),
//        fifo_cnt (NUM_CH x CW occupancies), th_hi_in/th_lo_in (thresholds sampled in INIT),
//        pause/cont/error_full (per channel), idle, init_out, state_o (one-hot state).
// Macro FLOW_CTRL_AUTORECOVER_EN: when defined, ERROR returns to IDLE after two all-empty cycles.
module flow_ctrl_fsm #(
  parameter int NUM_CH    = 4,
  parameter int DEPTH     = 8,
  parameter int CW        = 4,
  parameter int TH_HI_DEF = 6,
  parameter int TH_LO_DEF = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [NUM_CH*CW-1:0] fifo_cnt,
  input  logic [CW-1:0]        th_hi_in,
  input  logic [CW-1:0]        th_lo_in,
  output logic [NUM_CH-1:0]    pause,
  output logic [NUM_CH-1:0]    cont,
  output logic [NUM_CH-1:0]    error_full,
  output logic                 idle,
  output logic                 init_out,
  output logic [4:0]           state_o
);
  typedef enum logic [4:0] {
    S_RESET  = 5'b00001,
    S_INIT   = 5'b00010,
    S_IDLE   = 5'b00100,
    S_ACTIVE = 5'b01000,
    S_ERROR  = 5'b10000
  } state_t;
  localparam logic [CW:0] FULL = (CW+1)'(DEPTH);
  state_t state_q, state_d;
  logic [CW-1:0] th_hi_q, th_hi_d, th_lo_q, th_lo_d;
  logic [NUM_CH*CW-1:0] cnt_q;
  logic [NUM_CH-1:0] pause_q, pause_d, cont_q, cont_d, err_q, err_d, full;
  logic all_zero, th_ok;
`ifdef FLOW_CTRL_AUTORECOVER_EN
  logic zero_q, zero_d;
`endif
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) full[i] = {1'b0, fifo_cnt[i*CW +: CW]} >= FULL;
    all_zero = fifo_cnt == '0;
  end
  always_comb begin
    state_d = state_q;
`ifdef FLOW_CTRL_AUTORECOVER_EN
    zero_d = 1'b0;
`endif
    unique case (state_q)
      S_RESET:  state_d = S_INIT;
      S_INIT:   state_d = init ? S_INIT : S_IDLE;
      S_IDLE:   state_d = all_zero ? S_IDLE : S_ACTIVE;
      S_ACTIVE: state_d = all_zero ? S_IDLE : S_ACTIVE;
`ifdef FLOW_CTRL_AUTORECOVER_EN
      S_ERROR: begin
        zero_d  = all_zero;
        state_d = (all_zero && zero_q) ? S_IDLE : S_ERROR;
      end
`else
      S_ERROR:  state_d = S_ERROR;
`endif
      default:  state_d = S_RESET;
    endcase
    if ((|full) && (state_q == S_IDLE || state_q == S_ACTIVE)) state_d = S_ERROR;
    if (init && state_q != S_RESET) state_d = S_INIT;
  end
  always_comb begin
    th_ok   = (th_lo_in < th_hi_in) && ({1'b0, th_hi_in} <= FULL);
    th_hi_d = (state_q == S_INIT && th_ok) ? th_hi_in : th_hi_q;
    th_lo_d = (state_q == S_INIT && th_ok) ? th_lo_in : th_lo_q;
    for (int i = 0; i < NUM_CH; i++) begin
      // hysteresis runs on the registered count, so pause lags the input by two edges
      pause_d[i] = (state_d != S_ACTIVE) ? 1'b0 :
                   (cnt_q[i*CW +: CW] >= th_hi_q) ? 1'b1 :
                   (cnt_q[i*CW +: CW] <= th_lo_q) ? 1'b0 : pause_q[i];
      cont_d[i]  = pause_q[i] && !pause_d[i] && state_q == S_ACTIVE && state_d == S_ACTIVE;
      err_d[i]   = (state_d == S_INIT) ? 1'b0 :
                   err_q[i] | (full[i] && (state_q == S_IDLE || state_q == S_ACTIVE || state_q == S_ERROR));
    end
`ifdef FLOW_CTRL_AUTORECOVER_EN
    if (state_q == S_ERROR && state_d == S_IDLE) err_d = '0;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      th_hi_q <= CW'(TH_HI_DEF);
      th_lo_q <= CW'(TH_LO_DEF);
      cnt_q   <= '0;
      pause_q <= '0;
      cont_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      th_hi_q <= th_hi_d;
      th_lo_q <= th_lo_d;
      cnt_q   <= fifo_cnt;
      pause_q <= pause_d;
      cont_q  <= cont_d;
      err_q   <= err_d;
    end
  end
`ifdef FLOW_CTRL_AUTORECOVER_EN
  always_ff @(posedge clk) zero_q <= reset ? 1'b0 : zero_d;
`endif
  assign pause      = pause_q;
  assign cont       = cont_q;
  assign error_full = err_q;
  assign idle       = state_q == S_IDLE;
  assign init_out   = state_q == S_INIT;
  assign state_o    = state_q;
endmodule

// File: tb/tb_flow_ctrl_fsm.sv
// tb_flow_ctrl_fsm: directed scoreboard bench for flow_ctrl_fsm with default parameters.
module tb_flow_ctrl_fsm;
  localparam logic [4:0] RST = 5'b00001, INI = 5'b00010, IDL = 5'b00100, ACT = 5'b01000, ERR = 5'b10000;
  logic clk = 1'b0, reset = 1'b1, init = 1'b0;
  logic [15:0] fifo_cnt = '0;
  logic [3:0] th_hi_in = 4'd5, th_lo_in = 4'd1;
  logic [3:0] pause, cont, error_full;
  logic idle, init_out;
  logic [4:0] state_o;
  typedef struct {
    string tag;
    logic [4:0] st;
    logic [3:0] p, c, e;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  flow_ctrl_fsm dut (
    .clk(clk), .reset(reset), .init(init), .fifo_cnt(fifo_cnt),
    .th_hi_in(th_hi_in), .th_lo_in(th_lo_in), .pause(pause), .cont(cont),
    .error_full(error_full), .idle(idle), .init_out(init_out), .state_o(state_o)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] cv(input int c3, input int c2, input int c1, input int c0);
    return {4'(c3), 4'(c2), 4'(c1), 4'(c0)};
  endfunction
  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask
  task automatic step(input string tag, input logic r, input logic in, input logic [15:0] cnt,
                      input logic [4:0] st, input logic [3:0] p, input logic [3:0] c, input logic [3:0] e);
    exp_t x;
    reset = r;
    init = in;
    fifo_cnt = cnt;
    x.tag = tag; x.st = st; x.p = p; x.c = c; x.e = e;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({x.tag, ".state"}, state_o, x.st);
    chk({x.tag, ".pause"}, {1'b0, pause}, {1'b0, x.p});
    chk({x.tag, ".cont"}, {1'b0, cont}, {1'b0, x.c});
    chk({x.tag, ".err"}, {1'b0, error_full}, {1'b0, x.e});
    chk({x.tag, ".idle"}, {4'b0, idle}, {4'b0, x.st == IDL});
    chk({x.tag, ".init_out"}, {4'b0, init_out}, {4'b0, x.st == INI});
  endtask
  initial begin
    step("rst",     1, 0, cv(0,0,0,0), RST, 4'b0000, 4'b0000, 4'b0000);
    step("init1",   0, 1, cv(0,0,0,0), INI, 4'b0000, 4'b0000, 4'b0000);
    step("init2",   0, 1, cv(0,0,0,0), INI, 4'b0000, 4'b0000, 4'b0000);
    step("init3",   0, 1, cv(0,0,0,0), INI, 4'b0000, 4'b0000, 4'b0000);
    step("to_idle", 0, 0, cv(0,0,0,0), IDL, 4'b0000, 4'b0000, 4'b0000);
    step("ramp1",   0, 0, cv(0,1,0,0), ACT, 4'b0000, 4'b0000, 4'b0000);
    step("ramp2",   0, 0, cv(0,2,0,0), ACT, 4'b0000, 4'b0000, 4'b0000);
    step("ramp3",   0, 0, cv(0,3,0,0), ACT, 4'b0000, 4'b0000, 4'b0000);
    step("ramp4",   0, 0, cv(0,4,0,0), ACT, 4'b0000, 4'b0000, 4'b0000);
    step("ramp5",   0, 0, cv(0,5,0,0), ACT, 4'b0000, 4'b0000, 4'b0000);
    step("hi_hit",  0, 0, cv(0,5,0,0), ACT, 4'b0100, 4'b0000, 4'b0000);
    step("fall3",   0, 0, cv(0,3,0,0), ACT, 4'b0100, 4'b0000, 4'b0000);
    step("fall2",   0, 0, cv(0,2,0,0), ACT, 4'b0100, 4'b0000, 4'b0000);
    step("fall1",   0, 0, cv(0,1,0,0), ACT, 4'b0100, 4'b0000, 4'b0000);
    step("lo_hit",  0, 0, cv(0,1,0,0), ACT, 4'b0000, 4'b0100, 4'b0000);
    step("cont_end",0, 0, cv(0,1,0,0), ACT, 4'b0000, 4'b0000, 4'b0000);
    step("dual_full",0,0, cv(8,1,0,8), ERR, 4'b0000, 4'b0000, 4'b1001);
    step("err_z1",  0, 0, cv(0,0,0,0), ERR, 4'b0000, 4'b0000, 4'b1001);
`ifdef FLOW_CTRL_AUTORECOVER_EN
    step("recover", 0, 0, cv(0,0,0,0), IDL, 4'b0000, 4'b0000, 4'b0000);
    step("rec_idle",0, 0, cv(0,0,0,0), IDL, 4'b0000, 4'b0000, 4'b0000);
`else
    step("err_z2",  0, 0, cv(0,0,0,0), ERR, 4'b0000, 4'b0000, 4'b1001);
    step("err_z3",  0, 0, cv(0,0,0,0), ERR, 4'b0000, 4'b0000, 4'b1001);
`endif
    step("rst2",    1, 0, cv(0,0,0,0), RST, 4'b0000, 4'b0000, 4'b0000);
    th_hi_in = 4'd4;
    th_lo_in = 4'd6;
    step("bad_th1", 0, 1, cv(0,0,0,0), INI, 4'b0000, 4'b0000, 4'b0000);
    step("bad_th2", 0, 1, cv(0,0,0,0), INI, 4'b0000, 4'b0000, 4'b0000);
    step("bad_th3", 0, 0, cv(0,0,0,0), IDL, 4'b0000, 4'b0000, 4'b0000);
    step("def5a",   0, 0, cv(0,0,5,0), ACT, 4'b0000, 4'b0000, 4'b0000);
    step("def5b",   0, 0, cv(0,0,5,0), ACT, 4'b0000, 4'b0000, 4'b0000);
    step("def6",    0, 0, cv(0,0,6,0), ACT, 4'b0000, 4'b0000, 4'b0000);
    step("def_hi",  0, 0, cv(0,0,2,0), ACT, 4'b0010, 4'b0000, 4'b0000);
    step("def_lo",  0, 0, cv(0,0,2,0), ACT, 4'b0000, 4'b0010, 4'b0000);
    step("all7a",   0, 0, cv(7,7,7,7), ACT, 4'b0000, 4'b0000, 4'b0000);
    step("all7b",   0, 0, cv(7,7,7,7), ACT, 4'b1111, 4'b0000, 4'b0000);
    step("mid_rst", 1, 0, cv(7,7,7,7), RST, 4'b0000, 4'b0000, 4'b0000);
    step("re_init", 0, 0, cv(0,0,0,0), INI, 4'b0000, 4'b0000, 4'b0000);
    step("re_idle", 0, 0, cv(0,0,0,0), IDL, 4'b0000, 4'b0000, 4'b0000);
    step("over9",   0, 0, cv(0,0,9,0), ERR, 4'b0000, 4'b0000, 4'b0010);
    step("err_acc", 0, 0, cv(0,0,0,8), ERR, 4'b0000, 4'b0000, 4'b0011);
    step("err_init",0, 1, cv(0,0,0,0), INI, 4'b0000, 4'b0000, 4'b0000);
    step("fin_idle",0, 0, cv(0,0,0,0), IDL, 4'b0000, 4'b0000, 4'b0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
